stepper_seq_driver: RTL

Parametrised successor to the single-purpose cut motor driver. It drives a 4-wire unipolar stepper through a move of N steps, with selectable direction, full- or half-step mode, per-move speed, abort, and a post-move settle time. It sits between the top-level controller FSM and the motor output pins. The controller issues a start/steps/dir request and waits for a one-cycle done pulse, the same handshake as the cut request/end pair.

---
 rtl/stepper_pkg.sv | 26 ++
 rtl/stepper_tick_gen.sv | 26 ++
 rtl/stepper_seq_driver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the unipolar stepper sequencer: state codes, phase table
// and phase-index stepping.
package stepper_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Coil patterns {A,B,A',B'}; index 0 in the low nibble, index 7 in the high nibble.
  localparam logic [31:0] PHASE_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                       4'b0110, 4'b0100, 4'b1100, 4'b1000};

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    return PHASE_TBL[{idx, 2'b00} +: 4];
  endfunction

  // Full steps from an even index take a single move so they land on a two-coil entry.
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic dir,
                                          input logic half);
    logic [2:0] delta;
    delta = (half || !idx[0]) ? 3'd1 : 3'd2;
    return dir ? (idx + delta) : (idx - delta);
  endfunction

endpackage

// File: rtl/stepper_tick_gen.sv
// Loadable down-counter; tick_c is high while the count sits at zero.
module stepper_tick_gen #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = load_val_i;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
    tick_c = (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stepper_seq_driver.sv
// Move sequencer for a 4-wire unipolar stepper: N steps, direction, full/half step,
// per-move period, abort and post-move settle, with a start/done handshake.
module stepper_seq_driver #(
  parameter int unsigned STEP_PERIOD = 10000,
  parameter int unsigned PER_W       = 20,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SETTLE_CYC  = 1000,
  parameter bit          HOLD_TORQUE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic             half_i,
  input  logic [CNT_W-1:0] steps_i,
  input  logic [PER_W-1:0] speed_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] remain_o,
  output logic [3:0]       signal_o
);
  import stepper_pkg::*;

  localparam int unsigned SETTLE_LD = (SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       sig_q, sig_d;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic             dir_q, dir_d, half_q, half_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             tg_load;
  logic [PER_W-1:0] tg_val;
  logic             tick_c;

  stepper_tick_gen #(.W(PER_W)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tg_load),
    .load_val_i (tg_val),
    .tick_c     (tick_c)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sig_d     = sig_q;
    aborted_d = aborted_q;
    dir_d     = dir_q;
    half_d    = half_q;
    remain_d  = remain_q;
    period_d  = period_q;
    tg_load   = 1'b0;
    tg_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dir_d     = dir_i;
          half_d    = half_i;
          remain_d  = steps_i;
          period_d  = (speed_i == '0) ? PER_W'(STEP_PERIOD) : speed_i;
          aborted_d = 1'b0;
          if (steps_i == '0) begin
            state_d = ST_DONE;
          end else begin
            // Zero count makes the first RUN cycle a step cycle.
            state_d = ST_RUN;
            tg_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (tick_c) begin
          idx_d    = next_idx(idx_q, dir_q, half_q);
          sig_d    = phase_of(idx_d);
          remain_d = remain_q - CNT_W'(1);
          tg_load  = 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = (SETTLE_CYC == 0) ? ST_DONE : ST_SETTLE;
            tg_val  = PER_W'(SETTLE_LD);
          end else begin
            tg_val  = period_q - PER_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (tick_c) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
    if (!HOLD_TORQUE && state_d == ST_IDLE) sig_d = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      sig_q     <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      remain_q  <= '0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sig_q     <= sig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      remain_q  <= remain_d;
      period_q  <= period_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;
  assign remain_o  = remain_q;
  assign signal_o  = sig_q;

endmodule
